simd_prod_accumulator: RTL and testbench
========================================

// Module: simd_prod_accumulator
// PURPOSE
//  Downstream stage of the SIMD multiplier: consumes the two 19-bit product lanes (z0/z1)
//  and accumulates each lane independently over a frame of FRAME beats.
//  Presents the per-lane sums and sticky overflow flags through a valid/ready result port.
//  Sits between the DSP SIMD multiplier output and fabric logic; the intended use is dot products.
// PARAMETERS
//  PROD_W    19  width of each input product lane (unsigned)
//  ACC_W     24  width of each lane accumulator; must be >= PROD_W
//  CNT_W     8   width of frame_len / beat counter
//  SATURATE  1   1: clamp lane at all-ones on overflow; 0: wrap modulo 2^ACC_W
// PORTS
//  clk        in   1       single clock, all state on rising edge
//  reset      in   1       asynchronous, active-high reset
//  start      in   1       begin a frame (honoured in IDLE, or in DONE together with out_ready)
//  frame_len  in   CNT_W   beats per frame, sampled with start; 0 means 2^CNT_W
//  in_valid   in   1       z0/z1 carry a valid product pair
//  in_ready   out  1       block accepts a product pair this cycle
//  z0         in   PROD_W  lane-0 product
//  z1         in   PROD_W  lane-1 product
//  out_valid  out  1       acc0/acc1/ovf0/ovf1 hold a completed frame
//  out_ready  in   1       consumer takes the result
//  acc0       out  ACC_W   lane-0 frame sum
//  acc1       out  ACC_W   lane-1 frame sum
//  ovf0       out  1       sticky: lane-0 sum exceeded 2^ACC_W-1 during frame
//  ovf1       out  1       sticky: lane-1 sum exceeded 2^ACC_W-1 during frame
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=0, out_valid=0, acc0=acc1=0, ovf0=ovf1=0, counter=0. Takes effect immediately.
//  The same reset behaviour applies mid-frame: the partial frame is discarded and no result is produced.
//  FSM states:
//   IDLE -> ACCUM on start: clear acc*/ovf*, load remaining=frame_len (0 -> 2^CNT_W).
//   ACCUM: in_ready=1. A beat is accepted when in_valid&in_ready.
//     On accept: acc_n <= acc_n + zext(z_n) and remaining decrements.
//     Remaining==1 on accept -> DONE. start is ignored in ACCUM.
//   DONE: in_ready=0, out_valid=1; outputs stable until out_ready.
//     out_ready without start -> IDLE.
//     out_ready with start -> ACCUM directly (back-to-back frame, clears acc*/ovf*, loads new frame_len).
//     start without out_ready -> ignored.
//  Latency: out_valid rises on the clock edge that accepts the last beat, so it is visible 1 cycle after that beat.
//  Full throughput: 1 beat/cycle in ACCUM. Bubbles (in_valid=0) do not advance the counter.
//  Arithmetic: unsigned; the lane sum is computed at ACC_W+1 bits, and the carry-out sets ovf_n (sticky).
//    SATURATE=1: lane clamps to {ACC_W{1'b1}}. Further adds keep it clamped.
//    SATURATE=0: lane keeps the low ACC_W bits.
//  Lanes are fully independent: overflow on one lane never affects the other.
//  acc*/ovf* are valid only while out_valid=1; they hold their last value otherwise (not cleared until the next start).
// STRUCTURE
//  Package simd_acc_pkg: state enum {IDLE,ACCUM,DONE}, default PROD_W/ACC_W/CNT_W localparams.
//  Sub-module simd_acc_lane (PROD_W, ACC_W, SATURATE): clear, en, prod -> acc, ovf.
//    Instantiated twice; the top holds the FSM, the counter and the handshakes.
// TESTING
//  1 Reset: assert reset mid-ACCUM (after 2 of 4 beats).
//    -> in_ready=0 and out_valid=0 immediately; acc*=0; no result appears afterwards.
//  2 Basic frame: frame_len=4, z0=0x7FA01 (1023*511) x4, z1=0x00001 x4.
//    -> acc0=0x1FE804, acc1=0x000004, ovf*=0, out_valid 1 cycle after beat 4.
//  3 Overflow, SATURATE=1: frame_len=33, z0=0x7FA01 each beat.
//    -> acc0=0xFFFFFF, ovf0=1. With frame_len=32 instead -> acc0=0xFF4020, ovf0=0.
//    Lane 1 (z1=0) -> acc1=0, ovf1=0.
//  4 Backpressure/bubbles: frame_len=3, in_valid toggled 1,0,1,0,1; hold out_ready=0 for 5 cycles.
//    -> exactly 3 beats summed; outputs stable while out_valid=1; start pulses in DONE ignored.
//  5 Back-to-back: in DONE, assert out_ready and start with frame_len=2.
//    -> next cycle state ACCUM, in_ready=1, acc*=0; second frame sums correctly.
//  6 frame_len=0 with z0=1 each beat -> out_valid only after 256 beats, acc0=0x000100.

Source files
------------

// File: rtl/simd_acc_pkg.sv
// Shared types and default widths for the SIMD product accumulator.
//   state_t      : frame FSM states
//   *_W_D        : default lane/accumulator/counter widths
//   NUM_LANES    : number of product lanes fed by the SIMD multiplier
package simd_acc_pkg;
  localparam int PROD_W_D  = 19;
  localparam int ACC_W_D   = 24;
  localparam int CNT_W_D   = 8;
  localparam int NUM_LANES = 2;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
endpackage

// File: rtl/simd_prod_accumulator_if.sv
// Bus bundle for simd_prod_accumulator.
//   start/frame_len        : frame control
//   in_valid/in_ready/z0/z1: product-pair input handshake
//   out_valid/out_ready    : result handshake; acc0/acc1/ovf0/ovf1 result payload
// master = producer/consumer side (testbench, fabric); slave = accumulator.
interface simd_prod_accumulator_if
  import simd_acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_D,
  parameter int ACC_W  = ACC_W_D,
  parameter int CNT_W  = CNT_W_D
);
  logic              start;
  logic [CNT_W-1:0]  frame_len;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] z0;
  logic [PROD_W-1:0] z1;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc0;
  logic [ACC_W-1:0]  acc1;
  logic              ovf0;
  logic              ovf1;

  modport master (
    output start, frame_len, in_valid, z0, z1, out_ready,
    input  in_ready, out_valid, acc0, acc1, ovf0, ovf1
  );

  modport slave (
    input  start, frame_len, in_valid, z0, z1, out_ready,
    output in_ready, out_valid, acc0, acc1, ovf0, ovf1
  );
endinterface

// File: rtl/simd_acc_lane.sv
// One accumulator lane: acc <= acc + zext(prod) when en, cleared by clear.
//   clk, reset : clock, async active-high reset
//   clear      : zero acc/ovf (frame start); has priority over en
//   en         : add prod this cycle
//   prod       : unsigned product lane
//   acc, ovf   : running sum and sticky carry-out flag
module simd_acc_lane #(
  parameter int PROD_W   = 19,
  parameter int ACC_W    = 24,
  parameter bit SATURATE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf
);
  // One extra bit so the carry-out is visible directly.
  logic [ACC_W:0] sum;
  assign sum = {1'b0, acc} + {{(ACC_W+1-PROD_W){1'b0}}, prod};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      if (sum[ACC_W]) begin
        ovf <= 1'b1;
        // Once clamped at all-ones any further nonzero add carries again,
        // so the lane stays pinned without extra state.
        acc <= SATURATE ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
      end else begin
        acc <= sum[ACC_W-1:0];
      end
    end
  end
endmodule

// File: rtl/simd_prod_accumulator.sv
// Accumulates the two SIMD product lanes over a frame of frame_len beats and
// presents per-lane sums plus sticky overflow flags on a valid/ready port.
//   clk, reset : clock, async active-high reset (drops a partial frame)
//   bus        : simd_prod_accumulator_if.slave (control, input and result handshakes)
module simd_prod_accumulator
  import simd_acc_pkg::*;
#(
  parameter int PROD_W   = PROD_W_D,
  parameter int ACC_W    = ACC_W_D,
  parameter int CNT_W    = CNT_W_D,
  parameter bit SATURATE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  simd_prod_accumulator_if.slave bus
);
  state_t           state, state_nx;
  // One bit wider than frame_len so frame_len==0 can load 2^CNT_W.
  logic [CNT_W:0]   remaining;
  logic             load;
  logic             accept;
  logic             in_ready_c;
  logic             out_valid_c;

  logic [NUM_LANES-1:0][PROD_W-1:0] prod;
  logic [NUM_LANES-1:0][ACC_W-1:0]  acc;
  logic [NUM_LANES-1:0]             ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    load        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load     = 1'b1;
          state_nx = ACCUM;
        end
      end
      ACCUM: begin
        in_ready_c = 1'b1;
        if (bus.in_valid && remaining == (CNT_W+1)'(1)) state_nx = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        // start alone is ignored here; only a handed-off result frees the block.
        if (bus.out_ready) begin
          if (bus.start) begin
            load     = 1'b1;
            state_nx = ACCUM;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign accept = in_ready_c & bus.in_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining <= '0;
    end else if (load) begin
      remaining <= (bus.frame_len == '0) ? {1'b1, {CNT_W{1'b0}}}
                                         : {1'b0, bus.frame_len};
    end else if (accept) begin
      remaining <= remaining - (CNT_W+1)'(1);
    end
  end

  assign prod = {bus.z1, bus.z0};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    simd_acc_lane #(
      .PROD_W   (PROD_W),
      .ACC_W    (ACC_W),
      .SATURATE (SATURATE)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .clear (load),
      .en    (accept),
      .prod  (prod[g]),
      .acc   (acc[g]),
      .ovf   (ovf[g])
    );
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.acc0      = acc[0];
  assign bus.acc1      = acc[1];
  assign bus.ovf0      = ovf[0];
  assign bus.ovf1      = ovf[1];
endmodule

// File: tb/tb_simd_prod_accumulator.sv
module tb_simd_prod_accumulator;
  localparam longint ACC_MAX = 64'h0000_0000_00FF_FFFF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  // Model: sum of accepted beats per lane in plain integer arithmetic.
  longint s0, s1;

  simd_prod_accumulator_if b ();

  simd_prod_accumulator dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_acc(input longint s);
    return (s > ACC_MAX) ? 32'(ACC_MAX) : 32'(s);
  endfunction

  function automatic logic [31:0] exp_ovf(input longint s);
    return (s > ACC_MAX) ? 32'd1 : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a frame; ordy=1 launches it from DONE as a back-to-back frame.
  task automatic start_frame(input int len, input bit ordy);
    b.start     = 1'b1;
    b.frame_len = len[7:0];
    b.out_ready = ordy;
    tick();
    b.start     = 1'b0;
    b.out_ready = 1'b0;
    s0 = 0;
    s1 = 0;
    chk("start_in_ready", 32'(b.in_ready), 32'd1);
    chk("start_out_valid", 32'(b.out_valid), 32'd0);
    chk("start_acc0_clr", 32'(b.acc0), 32'd0);
    chk("start_acc1_clr", 32'(b.acc1), 32'd0);
  endtask

  // bmode: 0 no bubbles, 1 alternate valid/bubble, 2 random bubbles.
  task automatic feed(input int n, input logic [18:0] f0, input logic [18:0] f1,
                      input bit rnd, input int bmode);
    int got = 0;
    int cyc = 0;
    int r;
    bit v;
    while (got < n && cyc < n * 4 + 20) begin
      case (bmode)
        1:       v = (cyc % 2 == 0);
        2:       v = ($urandom_range(99) >= 30);
        default: v = 1'b1;
      endcase
      b.in_valid = v;
      r = $urandom; b.z0 = rnd ? r[18:0] : f0;
      r = $urandom; b.z1 = rnd ? r[18:0] : f1;
      if (got > 0 && got < n) chk("mid_out_valid", 32'(b.out_valid), 32'd0);
      tick();
      cyc++;
      if (v) begin
        s0 += longint'(b.z0);
        s1 += longint'(b.z1);
        got++;
      end
    end
    b.in_valid = 1'b0;
    chk("feed_beats", 32'(got), 32'(n));
    chk("done_out_valid", 32'(b.out_valid), 32'd1);
    chk("done_in_ready", 32'(b.in_ready), 32'd0);
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_acc0"}, 32'(b.acc0), exp_acc(s0));
    chk({tag, "_acc1"}, 32'(b.acc1), exp_acc(s1));
    chk({tag, "_ovf0"}, 32'(b.ovf0), exp_ovf(s0));
    chk({tag, "_ovf1"}, 32'(b.ovf1), exp_ovf(s1));
  endtask

  // Hold out_ready low, optionally poking start, and require a frozen result.
  task automatic hold(input int cycles, input bit poke);
    for (int i = 0; i < cycles; i++) begin
      b.start = poke;
      b.frame_len = 8'd7;
      tick();
      chk("hold_out_valid", 32'(b.out_valid), 32'd1);
      chk("hold_in_ready", 32'(b.in_ready), 32'd0);
      chk("hold_acc0", 32'(b.acc0), exp_acc(s0));
      chk("hold_acc1", 32'(b.acc1), exp_acc(s1));
    end
    b.start = 1'b0;
  endtask

  task automatic release_result();
    b.out_ready = 1'b1;
    tick();
    b.out_ready = 1'b0;
    chk("rel_out_valid", 32'(b.out_valid), 32'd0);
    chk("rel_in_ready", 32'(b.in_ready), 32'd0);
    chk("rel_acc0_hold", 32'(b.acc0), exp_acc(s0));
  endtask

  initial begin
    int len;
    b.start = 1'b0; b.frame_len = '0; b.in_valid = 1'b0;
    b.z0 = '0; b.z1 = '0; b.out_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_in_ready", 32'(b.in_ready), 32'd0);
    chk("rst_out_valid", 32'(b.out_valid), 32'd0);
    chk("rst_acc0", 32'(b.acc0), 32'd0);
    chk("rst_ovf0", 32'(b.ovf0), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Reset mid-frame after 2 of 4 beats
    start_frame(4, 1'b0);
    b.in_valid = 1'b1; b.z0 = 19'h00005; b.z1 = 19'h00003;
    tick();
    tick();
    chk("pre_rst_acc0", 32'(b.acc0), 32'd10);
    #2 reset = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(b.in_ready), 32'd0);
    chk("midrst_out_valid", 32'(b.out_valid), 32'd0);
    chk("midrst_acc0", 32'(b.acc0), 32'd0);
    chk("midrst_acc1", 32'(b.acc1), 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("postrst_out_valid", 32'(b.out_valid), 32'd0);
      chk("postrst_in_ready", 32'(b.in_ready), 32'd0);
    end
    b.in_valid = 1'b0;

    // Basic frame
    start_frame(4, 1'b0);
    feed(4, 19'h7FA01, 19'h00001, 1'b0, 0);
    chk("basic_acc0_const", 32'(b.acc0), 32'h1FE804);
    chk("basic_acc1_const", 32'(b.acc1), 32'h000004);
    check_result("basic");
    release_result();

    // Overflow with saturation, and the just-fits case
    start_frame(33, 1'b0);
    feed(33, 19'h7FA01, 19'h00000, 1'b0, 0);
    chk("sat_acc0_const", 32'(b.acc0), 32'hFFFFFF);
    chk("sat_ovf0_const", 32'(b.ovf0), 32'd1);
    check_result("sat33");
    release_result();
    start_frame(32, 1'b0);
    feed(32, 19'h7FA01, 19'h00000, 1'b0, 0);
    chk("fit_acc0_const", 32'(b.acc0), 32'hFF4020);
    check_result("fit32");
    release_result();

    // Bubbles and backpressure with ignored start pulses
    start_frame(3, 1'b0);
    feed(3, 19'h12345, 19'h54321, 1'b0, 1);
    check_result("bubble");
    hold(5, 1'b1);
    check_result("bubble_held");

    // Back-to-back frame launched from DONE
    start_frame(2, 1'b1);
    feed(2, 19'h40000, 19'h7FFFF, 1'b0, 0);
    check_result("b2b");
    release_result();

    // frame_len = 0 means 256 beats
    start_frame(0, 1'b0);
    feed(256, 19'h00001, 19'h00000, 1'b0, 0);
    chk("len0_acc0_const", 32'(b.acc0), 32'h000100);
    check_result("len0");
    release_result();

    // Randomized frames against the model
    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(40, 1);
      start_frame(len, 1'b0);
      feed(len, '0, '0, 1'b1, 2);
      check_result("rand");
      hold($urandom_range(3, 0), 1'($urandom_range(1, 0)));
      release_result();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
